// File: rtl/logic_basic_debouncer.sv
// Per-bit level debouncer: each channel only follows its input after STABLE_CYCLES
// consecutive samples disagree with the current output, and emits one-cycle edge pulses.
module logic_basic_debouncer #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Guarded so an illegal STABLE_CYCLES still reaches the elaboration error below.
    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } state_t;

    generate
        if (WIDTH < 1 || STABLE_CYCLES < 1) begin : g_bad_params
            $error("logic_basic_debouncer: WIDTH and STABLE_CYCLES must both be >= 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            state_t        state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic          rise_reg, rise_next;
            logic          fall_reg, fall_next;
            logic          level;

            assign level = (state_reg == STABLE_HIGH) || (state_reg == CHECK_LOW);

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    state_reg <= STABLE_LOW;
                    cnt_reg   <= '0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                if (i[gi] == level) begin
                    // Any agreeing sample throws away the partial count.
                    cnt_next   = '0;
                    state_next = level ? STABLE_HIGH : STABLE_LOW;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = i[gi] ? STABLE_HIGH : STABLE_LOW;
                    rise_next  = i[gi];
                    fall_next  = ~i[gi];
                end else begin
                    cnt_next   = cnt_reg + CW'(1);
                    state_next = level ? CHECK_LOW : CHECK_HIGH;
                end
            end

            assign o[gi]    = level;
            assign rise[gi] = rise_reg;
            assign fall[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: doc/logic_basic_debouncer.md
LOGIC_BASIC_DEBOUNCER -- requirements
Module: logic_basic_debouncer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 1 and set the number of independent channels.
REQ-003 Parameter STABLE_CYCLES SHALL default to 4 and set the consecutive differing samples required before an output change.
REQ-004 Port aclk SHALL be an input, 1 bit wide, and act as the rising-edge clock.
REQ-005 Port areset SHALL be an input, 1 bit wide, and act as the asynchronous active-high reset.
REQ-006 Port i SHALL be an input, WIDTH bits wide, and carry already-synchronized level inputs (synchronizer output).
REQ-007 Port o SHALL be an output, WIDTH bits wide, and carry the debounced registered levels.
REQ-008 Port rise SHALL be an output, WIDTH bits wide, carrying a one-cycle pulse per channel when o[b] goes 0->1.
REQ-009 Port fall SHALL be an output, WIDTH bits wide, carrying a one-cycle pulse per channel when o[b] goes 1->0.

Function
REQ-010 Each bit b SHALL be processed by an independent channel with its own counter cnt[b], width $clog2(STABLE_CYCLES+1), and no cross-bit interaction.
REQ-011 Each channel SHALL have 4 states:
  - STABLE_LOW (o=0, i=0)
  - CHECK_HIGH (o=0, i=1 counting)
  - STABLE_HIGH (o=1, i=1)
  - CHECK_LOW (o=1, i=0 counting)
REQ-012 On each clock edge with i[b]==o[b], the channel SHALL clear cnt[b] to 0 and return to its STABLE state; the output is unchanged.
REQ-013 On each clock edge with i[b]!=o[b] and cnt[b]<STABLE_CYCLES-1, the channel SHALL increment cnt[b] and enter or stay in its CHECK state.
REQ-014 On each clock edge with i[b]!=o[b] and cnt[b]==STABLE_CYCLES-1, the channel SHALL set o[b] to i[b], clear cnt[b], and enter the opposite STABLE state.
REQ-015 Latency: o[b] SHALL change at the STABLE_CYCLES-th consecutive rising edge sampling i[b]!=o[b]; a deviation shorter than STABLE_CYCLES samples SHALL never change o[b].
REQ-016 A single matching sample inside a CHECK state SHALL fully restart the count; the count is not decremented and not held.
REQ-017 rise[b] SHALL be registered and asserted for exactly the cycle following the edge at which o[b] goes 0->1; fall[b] SHALL behave the same for 1->0.
REQ-018 rise[b] and fall[b] SHALL never be asserted together, and neither SHALL be asserted on two consecutive cycles.
REQ-019 With STABLE_CYCLES==1, o SHALL equal i delayed by one cycle, with pulses on every change.
REQ-020 Simultaneous transitions on several bits SHALL produce simultaneous, independent pulses.
REQ-021 cnt[b] SHALL never exceed STABLE_CYCLES-1, with no wrap-around.
REQ-022 STABLE_CYCLES<1 or WIDTH<1 SHALL cause an elaboration error.

Reset
REQ-023 While areset=1, the block SHALL asynchronously force o=0, rise=0, fall=0, all cnt=0, and all states to STABLE_LOW, independent of aclk.
REQ-024 Reset asserted mid-count SHALL discard the partial count; after release a full STABLE_CYCLES samples SHALL be required again.
REQ-025 After reset release, an input already at 1 SHALL be treated as a 0->1 deviation and produce rise after STABLE_CYCLES samples.

Verification (WIDTH=2, STABLE_CYCLES=4 unless noted)
REQ-026 Reset check: assert areset with i=2'b11 and no clock running -> o=2'b00, rise=2'b00, fall=2'b00 immediately.
REQ-027 Rising transition: i=2'b01 held from edge 0 -> o=2'b01 after edge 3 (4th sample), rise=2'b01 for one cycle, fall=0 throughout.
REQ-028 Glitch rejection: i[0]=1 for 3 samples, then 0 for 1 sample, then 1 for 3 samples -> o[0] stays 0, no pulses; a 4th consecutive 1 sample -> o[0]=1 with rise[0].
REQ-029 Falling transition with independent bits: from o=2'b11, apply i=2'b00 on the same edge -> o=2'b00 after the 4th sample, fall=2'b11 in one cycle; separately, i[1] toggled alone changes only bit 1.
REQ-030 Mid-count reset: i=2'b01 for 2 samples, pulse areset, keep i=2'b01 -> o[0] rises exactly 4 samples after reset release, not 2.
REQ-031 STABLE_CYCLES=1: i pattern 0,1,1,0 -> o pattern delayed by one cycle, rise then fall pulses, each 1 cycle wide.
